// File: rtl/bus_ctrl_pkg.sv
// Shared types and elaboration helpers for the burst bus controller family.
// Holds the one-hot state encoding, beat/counter sizing and the SIZE encoding.
package bus_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_REQ  = 5'b00010,
    ST_ADDR = 5'b00100,
    ST_XFER = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

  function automatic int beats_f(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // A counter that only ever needs the value 0 still gets one bit.
  function automatic int cnt_w_f(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic int size_bytes_f(input int line_w);
    return line_w / 32'sd8;
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Saturating up-counter with synchronous clear and enable; flags the final count.
// Used for both the beat index and the ACK timeout.
module burst_beat_counter #(
  parameter int WIDTH = 2,
  parameter int LAST  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  // Count register: holds at LAST so it can never wrap inside a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WIDTH{1'b0}};
    end else if (clr) begin
      count <= {WIDTH{1'b0}};
    end else if (en && !last) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

  assign last = (count == LAST_V);

endmodule

// File: rtl/burst_bus_controller.sv
// Master-side controller moving one LINE_W line over the shared bus as BUS_W beats,
// with request latching, slave-paced beats, ACK timeout and a one-cycle completion pulse.
module burst_bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter int BUS_W   = 32,
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 16,
  parameter int SIZE_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              BUS_CLK,
  input  logic              RST,
  inout  wire  [BUS_W-1:0]  D,
  inout  wire  [ADDR_W-1:0] A,
  inout  wire  [SIZE_W-1:0] SIZE,
  inout  wire               RW,
  output logic              BR,
  input  logic              BG,
  output logic              ACK_OUT,
  input  logic              ACK_IN,
  output logic              DEST_OUT,
  input  logic              DEST_IN,
  input  logic              MOD_EN,
  input  logic              MOD_WR,
  input  logic [ADDR_W-1:0] MOD_A,
  input  logic [LINE_W-1:0] MOD_WRITE_DATA,
  output logic [LINE_W-1:0] MOD_READ_DATA,
  output logic              MOD_BUSY,
  output logic              MOD_R,
  output logic              MOD_ERR
);

  localparam int BEATS = beats_f(LINE_W, BUS_W);
  localparam int BCW   = cnt_w_f(BEATS);
  localparam int TCW   = cnt_w_f(TIMEOUT);
  localparam logic [SIZE_W-1:0] SIZE_VAL = SIZE_W'(size_bytes_f(LINE_W));

  state_e              state_r, state_nxt_s;
  logic                timeout_hit_s;
  logic                wr_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LINE_W-1:0]   wdata_r;
  logic [LINE_W-1:0]   rdata_r;
  logic [BCW-1:0]      beat_s;
  logic                beat_last_s;
  logic [TCW-1:0]      tmo_s;
  logic                tmo_last_s;
  logic                beat_en_s, beat_clr_s, tmo_en_s, tmo_clr_s;
  logic                capture_s;
  logic [BUS_W-1:0]    d_out_s;
  logic                br_r, ack_out_r, dest_out_r, busy_r, mod_r_r, mod_err_r;
  logic                bus_en_r, d_en_r;
  logic                dest_in_unused_s;

  assign dest_in_unused_s = DEST_IN;

  assign beat_en_s  = (state_r == ST_XFER) && ACK_IN;
  assign beat_clr_s = (state_r != ST_XFER);
  assign tmo_en_s   = (state_r == ST_ADDR);
  assign tmo_clr_s  = (state_r != ST_ADDR);
  assign capture_s  = (state_r == ST_XFER) && !wr_r && ACK_IN;

  burst_beat_counter #(.WIDTH(BCW), .LAST(BEATS - 1)) u_beat_cnt (
    .clk   (BUS_CLK),
    .rst   (RST),
    .clr   (beat_clr_s),
    .en    (beat_en_s),
    .count (beat_s),
    .last  (beat_last_s)
  );

  burst_beat_counter #(.WIDTH(TCW), .LAST(TIMEOUT - 1)) u_tmo_cnt (
    .clk   (BUS_CLK),
    .rst   (RST),
    .clr   (tmo_clr_s),
    .en    (tmo_en_s),
    .count (tmo_s),
    .last  (tmo_last_s)
  );

  // Next-state logic; ACK_IN takes priority over an expiring timeout.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MOD_EN) state_nxt_s = ST_REQ;
        else        state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (BG) state_nxt_s = ST_ADDR;
        else    state_nxt_s = ST_REQ;
      end
      ST_ADDR: begin
        if (ACK_IN) begin
          state_nxt_s = ST_XFER;
        end else if (tmo_last_s) begin
          state_nxt_s   = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_XFER: begin
        if (ACK_IN && beat_last_s) state_nxt_s = ST_DONE;
        else                       state_nxt_s = ST_XFER;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (RST) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Output strobes are registered from the next state so they line up with it.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      br_r       <= 1'b0;
      ack_out_r  <= 1'b0;
      dest_out_r <= 1'b0;
      bus_en_r   <= 1'b0;
      d_en_r     <= 1'b0;
      busy_r     <= 1'b0;
      mod_r_r    <= 1'b0;
      mod_err_r  <= 1'b0;
    end else begin
      br_r       <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_XFER);
      ack_out_r  <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_XFER);
      dest_out_r <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_XFER);
      bus_en_r   <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_XFER);
      d_en_r     <= (state_nxt_s == ST_XFER) && wr_r;
      busy_r     <= (state_nxt_s != ST_IDLE);
      mod_r_r    <= (state_nxt_s == ST_DONE);
      mod_err_r  <= (state_nxt_s == ST_DONE) && timeout_hit_s;
    end
  end

  // Request latch: captured only on acceptance, so later unit changes are ignored.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      wr_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
    end else if ((state_r == ST_IDLE) && MOD_EN) begin
      wr_r    <= MOD_WR;
      addr_r  <= MOD_A;
      wdata_r <= MOD_WRITE_DATA;
    end else begin
      wr_r    <= wr_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Read buffer: one beat slot per accepted ACK; otherwise holds.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      rdata_r <= {LINE_W{1'b0}};
    end else if (capture_s) begin
      rdata_r[int'(beat_s) * BUS_W +: BUS_W] <= D;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign d_out_s = wdata_r[int'(beat_s) * BUS_W +: BUS_W];

  assign D    = d_en_r   ? d_out_s  : {BUS_W{1'bz}};
  assign A    = bus_en_r ? addr_r   : {ADDR_W{1'bz}};
  assign SIZE = bus_en_r ? SIZE_VAL : {SIZE_W{1'bz}};
  assign RW   = bus_en_r ? wr_r     : 1'bz;

  assign BR            = br_r;
  assign ACK_OUT       = ack_out_r;
  assign DEST_OUT      = dest_out_r;
  assign MOD_BUSY      = busy_r;
  assign MOD_R         = mod_r_r;
  assign MOD_ERR       = mod_err_r;
  assign MOD_READ_DATA = rdata_r;

endmodule
